// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit:
// opcode values, ALU select codes, FSM states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [4:0] {
    RESET,
    FETCH0,
    FETCH1,
    FETCH2,
    DECODE,
    ALU3,
    ALU4,
    ALU5,
    IMM3,
    IMM4,
    IMM5,
    MEM3,
    MEM4,
    MEM5,
    MEM6,
    MEM7,
    NOP3,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_IMM,
    CLS_LD,
    CLS_ST,
    CLS_NOP,
    CLS_HALT
  } op_class_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Opcode classifier: maps the 5-bit opcode to an execution class and the
// ALU select used in the class's compute step. Unknown opcodes fall to NOP.
module ctrl_opdecode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op,
  output op_class_t  op_class,
  output logic [3:0] alu_op
);

  // Pure decode of the opcode field into class and ALU select.
  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    case (op)
      OP_LD:   op_class = CLS_LD;
      OP_ST:   op_class = CLS_ST;
      OP_ADD:  op_class = CLS_ALU;
      OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_ADDI: op_class = CLS_IMM;
      OP_ANDI: begin op_class = CLS_IMM; alu_op = ALU_AND; end
      OP_ORI:  begin op_class = CLS_IMM; alu_op = ALU_OR;  end
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit for a simple load/store CPU.
// The instruction class and ALU select are captured in DECODE so that every
// later output depends only on registered state, not on the live IR.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic [3:0]  ALU_op,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc
);

  state_t     state_q;
  state_t     state_d;
  op_class_t  cls_q;
  logic [3:0] alu_op_q;
  op_class_t  dec_class;
  logic [3:0] dec_alu_op;

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  ctrl_opdecode u_opdecode (
    .op       (IR[31:27]),
    .op_class (dec_class),
    .alu_op   (dec_alu_op)
  );

  // State register plus the class/ALU select latched while in DECODE.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= RESET;
      cls_q    <= CLS_NOP;
      alu_op_q <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        cls_q    <= dec_class;
        alu_op_q <= dec_alu_op;
      end
    end
  end

  // Next-state logic; Stop is only sampled on an instruction's last state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:  state_d = FETCH0;
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = DECODE;
      DECODE: begin
        case (dec_class)
          CLS_ALU:  state_d = ALU3;
          CLS_IMM:  state_d = IMM3;
          CLS_LD:   state_d = MEM3;
          CLS_ST:   state_d = MEM3;
          CLS_HALT: state_d = HALT;
          default:  state_d = NOP3;
        endcase
      end
      ALU3:   state_d = ALU4;
      ALU4:   state_d = ALU5;
      IMM3:   state_d = IMM4;
      IMM4:   state_d = IMM5;
      MEM3:   state_d = MEM4;
      MEM4:   state_d = MEM5;
      MEM5:   state_d = MEM6;
      MEM6:   state_d = MEM7;
      ALU5, IMM5, MEM7, NOP3: state_d = Stop ? HALT : FETCH0;
      HALT:   state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // Moore output decode from the present state (and the latched class).
  always_comb begin
    Run     = 1'b1;
    ALU_op  = ALU_ADD;
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    Cout    = 1'b0;
    BAout   = 1'b0;
    Rout    = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Rin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    case (state_q)
      FETCH0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      FETCH1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      FETCH2: begin MDRout = 1'b1; IRin = 1'b1; end
      ALU3, IMM3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      ALU4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = alu_op_q; end
      IMM4: begin Cout = 1'b1; Zin = 1'b1; ALU_op = alu_op_q; end
      ALU5, IMM5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      MEM3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      MEM4: begin Cout = 1'b1; Zin = 1'b1; end
      MEM5: begin Zlowout = 1'b1; MARin = 1'b1; end
      MEM6: begin
        MDRin = 1'b1;
        if (cls_q == CLS_ST) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      MEM7: begin
        if (cls_q == CLS_ST) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
      end
      HALT: Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected control
// vectors are queued when the IR is driven and compared cycle by cycle.
module tb_control_unit;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        Stop;
  logic        Run;
  logic [3:0]  ALU_op;
  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic        IncPC, Read, Write, Gra, Grb, Grc;

  control_unit dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .IR      (IR),
    .Stop    (Stop),
    .Run     (Run),
    .ALU_op  (ALU_op),
    .PCout   (PCout),
    .Zlowout (Zlowout),
    .MDRout  (MDRout),
    .Cout    (Cout),
    .BAout   (BAout),
    .Rout    (Rout),
    .MARin   (MARin),
    .Zin     (Zin),
    .PCin    (PCin),
    .MDRin   (MDRin),
    .IRin    (IRin),
    .Yin     (Yin),
    .Rin     (Rin),
    .IncPC   (IncPC),
    .Read    (Read),
    .Write   (Write),
    .Gra     (Gra),
    .Grb     (Grb),
    .Grc     (Grc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed view of every output: {Run, ALU_op, sources, loads, misc, selects}
  logic [23:0] dut_vec;
  assign dut_vec = {Run, ALU_op, PCout, Zlowout, MDRout, Cout, BAout, Rout,
                    MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
                    IncPC, Read, Write, Gra, Grb, Grc};

  localparam logic [23:0] B_RUN   = 24'h800000;
  localparam int          ALU_SH  = 19;
  localparam logic [23:0] B_PCOUT = 24'h1 << 18;
  localparam logic [23:0] B_ZLO   = 24'h1 << 17;
  localparam logic [23:0] B_MDRO  = 24'h1 << 16;
  localparam logic [23:0] B_COUT  = 24'h1 << 15;
  localparam logic [23:0] B_BAOUT = 24'h1 << 14;
  localparam logic [23:0] B_ROUT  = 24'h1 << 13;
  localparam logic [23:0] B_MARIN = 24'h1 << 12;
  localparam logic [23:0] B_ZIN   = 24'h1 << 11;
  localparam logic [23:0] B_PCIN  = 24'h1 << 10;
  localparam logic [23:0] B_MDRIN = 24'h1 << 9;
  localparam logic [23:0] B_IRIN  = 24'h1 << 8;
  localparam logic [23:0] B_YIN   = 24'h1 << 7;
  localparam logic [23:0] B_RIN   = 24'h1 << 6;
  localparam logic [23:0] B_INCPC = 24'h1 << 5;
  localparam logic [23:0] B_READ  = 24'h1 << 4;
  localparam logic [23:0] B_WRITE = 24'h1 << 3;
  localparam logic [23:0] B_GRA   = 24'h1 << 2;
  localparam logic [23:0] B_GRB   = 24'h1 << 1;
  localparam logic [23:0] B_GRC   = 24'h1;

  int n_checks;
  int n_pass;
  logic [23:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] alu_field(input logic [3:0] a);
    return {20'h0, a} << ALU_SH;
  endfunction

  // Queue the full expected output sequence for one instruction.
  task automatic push_expected(input logic [4:0] op);
    logic [3:0] a;
    exp_q.push_back(B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN);
    exp_q.push_back(B_RUN | B_ZLO | B_PCIN | B_READ | B_MDRIN);
    exp_q.push_back(B_RUN | B_MDRO | B_IRIN);
    exp_q.push_back(B_RUN);
    case (op)
      5'b00100, 5'b00101, 5'b01101: a = (op == 5'b00100) ? 4'd1 : 4'd2;
      5'b00110, 5'b01110:           a = 4'd3;
      default:                      a = 4'd0;
    endcase
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        exp_q.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
        exp_q.push_back(B_RUN | B_GRC | B_ROUT | B_ZIN | alu_field(a));
        exp_q.push_back(B_RUN | B_ZLO | B_GRA | B_RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_q.push_back(B_RUN | B_GRB | B_ROUT | B_YIN);
        exp_q.push_back(B_RUN | B_COUT | B_ZIN | alu_field(a));
        exp_q.push_back(B_RUN | B_ZLO | B_GRA | B_RIN);
      end
      5'b00000, 5'b00010: begin
        exp_q.push_back(B_RUN | B_GRB | B_BAOUT | B_YIN);
        exp_q.push_back(B_RUN | B_COUT | B_ZIN);
        exp_q.push_back(B_RUN | B_ZLO | B_MARIN);
        if (op == 5'b00000) begin
          exp_q.push_back(B_RUN | B_READ | B_MDRIN);
          exp_q.push_back(B_RUN | B_MDRO | B_GRA | B_RIN);
        end else begin
          exp_q.push_back(B_RUN | B_GRA | B_ROUT | B_MDRIN);
          exp_q.push_back(B_RUN | B_WRITE);
        end
      end
      5'b11011: ;
      default: exp_q.push_back(B_RUN);
    endcase
  endtask

  // Drive one instruction and compare each cycle; optionally raise Stop or
  // pulse Clear right after a given step has been checked.
  task automatic do_instr(input string name, input logic [31:0] ir,
                          input int stop_at, input int clear_at);
    int n;
    IR = ir;
    push_expected(ir[31:27]);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      check_eq($sformatf("%s step%0d", name, i), dut_vec, exp_q.pop_front());
      if (i == stop_at) Stop = 1'b1;
      if (i == clear_at) begin
        Clear = 1'b0;
        #1;
        check_eq($sformatf("%s async_clear", name), dut_vec, B_RUN);
        exp_q.delete();
        #2;
        Clear = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_halt(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock);
      #1;
      check_eq($sformatf("%s halt%0d", name, i), dut_vec, 24'h0);
    end
  endtask

  task automatic pulse_clear(input string name);
    Stop  = 1'b0;
    Clear = 1'b0;
    #1;
    check_eq($sformatf("%s clear", name), dut_vec, B_RUN);
    #2;
    Clear = 1'b1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [26:0] rest;
    rest = 27'($urandom);
    return {op, rest};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    Clear    = 1'b0;
    Stop     = 1'b0;
    IR       = 32'h0;
    #12;
    check_eq("reset_state", dut_vec, B_RUN);
    Clear = 1'b1;

    do_instr("addi", 32'h610FFFFB, -1, -1);
    do_instr("sub",  mk_ir(5'b00100), -1, -1);
    do_instr("add",  mk_ir(5'b00011), -1, -1);
    do_instr("and",  mk_ir(5'b00101), -1, -1);
    do_instr("or",   mk_ir(5'b00110), -1, -1);
    do_instr("andi", mk_ir(5'b01101), -1, -1);
    do_instr("ori",  mk_ir(5'b01110), -1, -1);
    do_instr("ld",   mk_ir(5'b00000), -1, -1);
    do_instr("st",   mk_ir(5'b00010), -1, -1);
    do_instr("nop",  mk_ir(5'b11010), -1, -1);
    do_instr("unk",  mk_ir(5'b11111), -1, -1);
    do_instr("unk2", mk_ir(5'b10101), -1, -1);

    // Stop raised during MEM5 of a load: load finishes, then HALT.
    do_instr("ld_stop", mk_ir(5'b00000), 6, -1);
    check_halt("ld_stop", 20);
    pulse_clear("after_stop");

    // Clear pulsed during MEM7 of a store.
    do_instr("st_clr", mk_ir(5'b00010), -1, 8);
    do_instr("post_clr", mk_ir(5'b00011), -1, -1);

    // halt opcode enters HALT from DECODE with Stop low.
    do_instr("halt", mk_ir(5'b11011), -1, -1);
    check_halt("halt", 5);
    pulse_clear("after_halt");
    do_instr("final_add", mk_ir(5'b00011), -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port Clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IR, input, 32, datapath IR contents; fields op[31:27], ra[26:23], rb[22:19], C[18:0].
REQ-004 SHALL have port Stop, input, 1, halt request.
REQ-005 SHALL have port Run, output, 1, high while executing, low in HALT.
REQ-006 SHALL have port ALU_op, output, 4, ALU select: ADD=0, SUB=1, AND=2, OR=3.
REQ-007 SHALL have ports PCout, Zlowout, MDRout, Cout, BAout, Rout, output, 1 each, bus-source selects.
REQ-008 SHALL have ports MARin, Zin, PCin, MDRin, IRin, Yin, Rin, output, 1 each, register load enables.
REQ-009 SHALL have ports IncPC, Read, Write, output, 1 each, PC increment, memory read/MDR mux, memory write.
REQ-010 SHALL have ports Gra, Grb, Grc, output, 1 each, register-file field selects.

Function
REQ-011 SHALL be a Moore FSM; every control output decodes from present state only, one state per Clock cycle.
REQ-012 SHALL have states RESET, FETCH0, FETCH1, FETCH2, DECODE, ALU3..ALU5, IMM3..IMM5, MEM3..MEM7, NOP3, HALT.
REQ-013 FETCH0: PCout, MARin, IncPC, Zin; FETCH1: Zlowout, PCin, Read, MDRin; FETCH2: MDRout, IRin.
REQ-014 DECODE asserts nothing; the next state comes from IR[31:27], which is stable there.
REQ-015 Opcodes: ld=00000, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, andi=01101, ori=01110, nop=11010, halt=11011.
REQ-016 Unlisted opcodes SHALL execute as nop.
REQ-017 ALU (add/sub/and/or): ALU3 Grb,Rout,Yin; ALU4 Grc,Rout,Zin, ALU_op per opcode; ALU5 Zlowout,Gra,Rin.
REQ-018 IMM (addi/andi/ori): IMM3 Grb,Rout,Yin; IMM4 Cout,Zin, ALU_op ADD/AND/OR; IMM5 Zlowout,Gra,Rin.
REQ-019 MEM (ld/st): MEM3 Grb,BAout,Yin; MEM4 Cout,Zin, ALU_op=ADD; MEM5 Zlowout,MARin.
REQ-020 ld: MEM6 Read,MDRin; MEM7 MDRout,Gra,Rin.
REQ-021 st: MEM6 Gra,Rout,MDRin with Read=0; MEM7 Write.
REQ-022 ALU_op SHALL be ADD (0) in every state other than ALU4/IMM4.
REQ-023 Latency: ALU/IMM 7 cycles, ld/st 9, nop 5 (FETCH0 to next FETCH0).
REQ-024 From the last state of an instruction, next state is HALT if Stop=1, else FETCH0.
REQ-025 Stop SHALL be ignored mid-instruction; no instruction is abandoned.
REQ-026 halt opcode SHALL enter HALT from DECODE regardless of Stop.
REQ-027 HALT SHALL persist until Clear; Run=0 and all control outputs 0 there.
REQ-028 At most one bus-source select SHALL be high in any state.

Reset
REQ-029 Clear low SHALL force RESET immediately; all outputs 0 except Run=1, even mid-instruction (e.g. during MEM7, Write drops at once).
REQ-030 First rising Clock after Clear deasserts SHALL move RESET to FETCH0.

Structure
REQ-031 Package cpu_ctrl_pkg SHALL hold opcode constants, ALU_op codes, and the state enumeration.
REQ-032 One sub-module, ctrl_opdecode, SHALL map op[31:27] to class {ALU, IMM, LD, ST, NOP, HALT} plus ALU_op; the FSM stays in control_unit.

Verification
REQ-033 IR=0x610FFFFB (addi R2,R1,#-5) -> FETCH0..IMM5 in 7 cycles; IMM4 shows Cout=1, Zin=1, ALU_op=0; IMM5 shows Gra=Rin=Zlowout=1.
REQ-034 IR op=00100 (sub) -> ALU4 shows Grc=Rout=Zin=1, ALU_op=1; next FETCH0 is 7 cycles after the previous one.
REQ-035 IR op=00010 (st) -> MEM6 Gra=Rout=MDRin=1 with Read=0; MEM7 Write=1; 9-cycle instruction.
REQ-036 Stop=1 raised during MEM5 of ld -> MEM6, MEM7 complete, then HALT with Run=0; outputs stay 0 for 20 cycles.
REQ-037 Clear pulsed low during MEM7 of st -> Write=0 asynchronously, Run=1; FETCH0 on the first edge after release.
REQ-038 IR op=11111 -> DECODE, NOP3, FETCH0 with no Rin/Write asserted; op=11011 -> HALT.
